sobel_edge_stream: RTL and testbench

- Parametrised streaming 3x3 Sobel edge detector; successor to the fixed 8-bit, fixed-threshold Sobel block in the edge-detection pipeline.
- Accepts one grey pixel per accepted cycle in raster order.
- Outputs either a saturated gradient magnitude or a thresholded black/white pixel, selected at runtime.
- Self-flushes at frame end, so every frame emits exactly IMG_W*IMG_H output pixels with start/end markers.

---
 rtl/sobel_pkg.sv | 17 +
 rtl/sobel_line_buffer.sv | 41 ++++
 rtl/sobel_edge_stream.sv | 189 ++++++++++++++++++
 tb/tb_sobel_edge_stream.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared constants, types and width helper for the streaming Sobel edge detector
package sobel_pkg;

    localparam logic MODE_BIN = 1'b0;
    localparam logic MODE_MAG = 1'b1;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    // Gradient width: three extra bits hold the signed range of +/-4*(2^DATA_W-1) and mag up to 8*(2^DATA_W-1)
    function automatic int grad_w(input int data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: two-row delay line giving the pixels one and two rows above the newest pixel
module sobel_line_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 180
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              shift_en_i,
    input  logic [DATA_W-1:0] pix_i,
    output logic [DATA_W-1:0] tap1_o,
    output logic [DATA_W-1:0] tap2_o
);

    localparam int PW = $clog2(IMG_W);
    localparam logic [PW-1:0] PTR_LAST = PW'(IMG_W - 1);

    logic [DATA_W-1:0] row1_q [IMG_W];
    logic [DATA_W-1:0] row2_q [IMG_W];
    logic [PW-1:0]     ptr_q;

    assign tap1_o = row1_q[ptr_q];
    assign tap2_o = row2_q[ptr_q];

    // Circular storage: the slot under the pointer is exactly IMG_W shifts old, so it is read then overwritten
    always_ff @(posedge sys_clk) begin
        if (shift_en_i) begin
            row1_q[ptr_q] <= pix_i;
            row2_q[ptr_q] <= row1_q[ptr_q];
        end
    end

    // Pointer wraps every IMG_W shifts; contents are never cleared since stale rows are masked downstream
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ptr_q <= '0;
        end else if (shift_en_i) begin
            ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/sobel_edge_stream.sv
// sobel_edge_stream: streaming 3x3 Sobel edge detector with magnitude/binary output and self-flush per frame
module sobel_edge_stream
    import sobel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 180,
    parameter int IMG_H  = 180
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              mode,
    input  logic [DATA_W+2:0] threshold,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_flag,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_flag,
    output logic              out_sof,
    output logic              out_eof
);

    localparam int GRAD_W = grad_w(DATA_W);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int FW = $clog2(IMG_W + 2);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [FW-1:0] FILL_MAX   = FW'(IMG_W + 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_W);

    state_t            state_q;
    logic              in_ready_q;
    logic [FW-1:0]     flush_cnt_q, fill_q;
    logic [CW-1:0]     in_col_q, out_col_q;
    logic [RW-1:0]     in_row_q, out_row_q;
    logic              real_acc, acc, produce;
    logic [DATA_W-1:0] pix, tap1, tap2;
    logic [DATA_W-1:0] win_q [3][3];

    logic              v1_q, v2_q, v3_q;
    logic              border1_q, sof1_q, eof1_q, mode1_q;
    logic              border2_q, sof2_q, eof2_q, mode2_q;
    logic              sof3_q, eof3_q;
    logic [GRAD_W-1:0] thr1_q, thr2_q;
    logic signed [GRAD_W-1:0] p [3][3];
    logic signed [GRAD_W-1:0] gx_d, gy_d, gx_q, gy_q;
    logic [GRAD_W-1:0] abs_x, abs_y, mag;
    logic [DATA_W-1:0] sat, res_d, res3_q;
    logic [DATA_W-1:0] data_out_q;
    logic              out_flag_q, out_sof_q, out_eof_q;

    // Phantom accepts during FLUSH push zeros through the window to drain the last rows
    assign real_acc = in_flag && in_ready_q;
    assign acc      = real_acc || (state_q == ST_FLUSH);
    assign produce  = acc && (fill_q == FILL_MAX);
    assign pix      = real_acc ? data_in : '0;

    sobel_line_buffer #(
        .DATA_W(DATA_W),
        .IMG_W (IMG_W)
    ) u_line_buffer (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .shift_en_i(acc),
        .pix_i     (pix),
        .tap1_o    (tap1),
        .tap2_o    (tap2)
    );

    // Frame control: input raster counters, RUN/FLUSH sequencing, window fill and output-position tracking
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_RUN;
            in_ready_q  <= 1'b1;
            flush_cnt_q <= '0;
            fill_q      <= '0;
            in_col_q    <= '0;
            in_row_q    <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
        end else begin
            if (acc && fill_q != FILL_MAX) fill_q <= fill_q + 1'b1;
            if (produce) begin
                out_col_q <= (out_col_q == COL_LAST) ? '0 : out_col_q + 1'b1;
                if (out_col_q == COL_LAST) out_row_q <= (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
            end
            if (state_q == ST_RUN) begin
                if (real_acc) begin
                    in_col_q <= (in_col_q == COL_LAST) ? '0 : in_col_q + 1'b1;
                    if (in_col_q == COL_LAST) in_row_q <= (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
                    if (in_col_q == COL_LAST && in_row_q == ROW_LAST) begin
                        state_q     <= ST_FLUSH;
                        in_ready_q  <= 1'b0;
                        flush_cnt_q <= '0;
                    end
                end
            end else begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_q    <= ST_RUN;
                    in_ready_q <= 1'b1;
                    fill_q     <= '0;
                    out_col_q  <= '0;
                    out_row_q  <= '0;
                end
            end
        end
    end

    // Shift the 3x3 window on every real or phantom accept; column 2 and row 2 hold the newest pixels
    always_ff @(posedge sys_clk) begin
        if (acc) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= tap2;
            win_q[1][2] <= tap1;
            win_q[2][2] <= pix;
        end
    end

    // Gradients from the zero-extended window
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                p[r][c] = $signed({{(GRAD_W - DATA_W){1'b0}}, win_q[r][c]});
            end
        end
        gx_d = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
        gy_d = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
    end

    // Magnitude, saturation and binary select; border pixels are forced to zero in both modes
    always_comb begin
        abs_x = gx_q[GRAD_W-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
        abs_y = gy_q[GRAD_W-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
        mag   = abs_x + abs_y;
        sat   = (|mag[GRAD_W-1:DATA_W]) ? '1 : mag[DATA_W-1:0];
        res_d = border2_q ? '0 : (mode2_q == MODE_MAG) ? sat : ((mag > thr2_q) ? '1 : '0);
    end

    // Datapath stages: tag the produced window, register gradients, register the selected result
    always_ff @(posedge sys_clk) begin
        border1_q <= (out_col_q == '0) || (out_col_q == COL_LAST) || (out_row_q == '0) || (out_row_q == ROW_LAST);
        sof1_q    <= (out_col_q == '0) && (out_row_q == '0);
        eof1_q    <= (out_col_q == COL_LAST) && (out_row_q == ROW_LAST);
        mode1_q   <= mode;
        thr1_q    <= threshold;
        gx_q      <= gx_d;
        gy_q      <= gy_d;
        border2_q <= border1_q;
        sof2_q    <= sof1_q;
        eof2_q    <= eof1_q;
        mode2_q   <= mode1_q;
        thr2_q    <= thr1_q;
        res3_q    <= res_d;
        sof3_q    <= sof2_q;
        eof3_q    <= eof2_q;
    end

    // Valid chain and output register; markers are gated by valid so they never appear alone
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            out_flag_q <= 1'b0;
            out_sof_q  <= 1'b0;
            out_eof_q  <= 1'b0;
            data_out_q <= '0;
        end else begin
            v1_q       <= produce;
            v2_q       <= v1_q;
            v3_q       <= v2_q;
            out_flag_q <= v3_q;
            out_sof_q  <= v3_q && sof3_q;
            out_eof_q  <= v3_q && eof3_q;
            if (v3_q) data_out_q <= res3_q;
        end
    end

    assign in_ready = in_ready_q;
    assign data_out = data_out_q;
    assign out_flag = out_flag_q;
    assign out_sof  = out_sof_q;
    assign out_eof  = out_eof_q;

endmodule

// File: tb/tb_sobel_edge_stream.sv
// tb_sobel_edge_stream: scoreboard bench for the streaming Sobel detector on a 5x4 frame
module tb_sobel_edge_stream;

    localparam int W = 5;
    localparam int H = 4;
    localparam int N = W * H;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        mode = 1'b1;
    logic [10:0] threshold = '0;
    logic [7:0]  data_in = '0;
    logic        in_flag = 1'b0;
    logic        in_ready;
    logic [7:0]  data_out;
    logic        out_flag, out_sof, out_eof;

    always #5 sys_clk = ~sys_clk;

    sobel_edge_stream #(
        .DATA_W(8),
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .mode     (mode),
        .threshold(threshold),
        .data_in  (data_in),
        .in_flag  (in_flag),
        .in_ready (in_ready),
        .data_out (data_out),
        .out_flag (out_flag),
        .out_sof  (out_sof),
        .out_eof  (out_eof)
    );

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        int         due;
    } exp_t;

    exp_t pend[$];
    exp_t sb[$];
    exp_t me;
    int   fr [N];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_real = 0;
    int   m_ph = 0;
    logic m_fl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int px(input int r, input int c);
        return fr[r * W + c];
    endfunction

    function automatic logic [7:0] gold(input int k, input logic md, input int thr);
        int r, c, gx, gy, mag;
        r = k / W;
        c = k % W;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
        gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
        gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (md) return (mag > 255) ? 8'd255 : 8'(mag);
        return (mag > thr) ? 8'd255 : 8'd0;
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.data = gold(k, mode, int'(threshold));
            e.sof  = (k == 0);
            e.eof  = (k == N - 1);
            e.due  = 0;
            pend.push_back(e);
        end
    endtask

    task automatic send(input int p, input int gap);
        bit ok;
        repeat (gap) begin
            in_flag = 1'b0;
            @(posedge sys_clk);
            #1;
        end
        in_flag = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge sys_clk);
            if (in_ready) begin
                data_in = 8'(p);
                ok = 1'b1;
            end else begin
                data_in = 8'($urandom);
            end
        end
        if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run_frame(input int gapmax);
        push_frame();
        for (int k = 0; k < N; k++) send(fr[k], int'($urandom_range(gapmax)));
    endtask

    task automatic drain();
        in_flag = 1'b0;
        repeat (16) @(posedge sys_clk);
        #1;
    endtask

    task automatic set_step(input int lo, input int hi);
        for (int k = 0; k < N; k++) fr[k] = (k % W >= 3) ? hi : lo;
    endtask

    task automatic set_random();
        for (int k = 0; k < N; k++) fr[k] = int'($urandom_range(255));
    endtask

    always @(posedge sys_clk) cyc++;

    // Output checker and accept model: expectations move from pend to sb on each producing accept
    always @(negedge sys_clk) begin
        if (out_flag) begin
            if (sb.size() == 0) begin
                chk("out_flag_extra", 32'(out_flag), 32'd0);
            end else begin
                me = sb.pop_front();
                chk("data", 32'(data_out), 32'(me.data));
                chk("sof", 32'(out_sof), 32'(me.sof));
                chk("eof", 32'(out_eof), 32'(me.eof));
                chk("latency_cycle", 32'(cyc), 32'(me.due));
            end
        end else begin
            chk("marker_without_flag", 32'({out_sof, out_eof}), 32'd0);
            if (sb.size() != 0 && sb[0].due <= cyc) begin
                me = sb.pop_front();
                chk("missing_output", 32'(out_flag), 32'd1);
            end
        end
        if (sys_rst) begin
            m_real = 0;
            m_ph = 0;
            sb.delete();
            pend.delete();
        end else begin
            m_fl = (m_real == N);
            chk("in_ready", 32'(in_ready), 32'(!m_fl));
            if (in_flag || m_fl) begin
                if (m_real + m_ph >= W + 1) begin
                    if (pend.size() == 0) begin
                        chk("pending_underflow", 32'(pend.size()), 32'd1);
                    end else begin
                        me = pend.pop_front();
                        me.due = cyc + 4;
                        sb.push_back(me);
                    end
                end
                if (m_fl) begin
                    m_ph++;
                    if (m_ph == W + 1) begin
                        m_real = 0;
                        m_ph = 0;
                    end
                end else begin
                    m_real++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_out_flag", 32'(out_flag), 32'd0);
        chk("rst_out_sof", 32'(out_sof), 32'd0);
        chk("rst_out_eof", 32'(out_eof), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;

        mode = 1'b1;
        for (int k = 0; k < N; k++) fr[k] = 100;
        run_frame(0);
        drain();

        set_step(0, 200);
        run_frame(0);
        drain();
        mode = 1'b0;
        threshold = 11'd12;
        run_frame(0);
        drain();

        set_step(0, 3);
        run_frame(0);
        drain();
        threshold = 11'd11;
        run_frame(0);
        drain();
        mode = 1'b1;
        run_frame(0);
        drain();

        set_random();
        run_frame(4);
        drain();
        run_frame(0);
        drain();

        set_random();
        run_frame(0);
        set_random();
        run_frame(0);
        drain();

        set_random();
        push_frame();
        for (int k = 0; k < 10; k++) send(fr[k], 0);
        sys_rst = 1'b1;
        in_flag = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("midrst_data_out", 32'(data_out), 32'd0);
        chk("midrst_out_flag", 32'(out_flag), 32'd0);
        chk("midrst_out_sof", 32'(out_sof), 32'd0);
        chk("midrst_out_eof", 32'(out_eof), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge sys_clk);
        #1;
        set_random();
        run_frame(1);
        drain();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("pending_empty", 32'(pend.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
